// File: rtl/mem_arb_types.sv
// mem_arb_types: shared FSM state, grant port enums and word-align mask for mem_port_arbiter
package mem_arb_types;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {PORT_INST = 1'b0, PORT_DATA = 1'b1} arb_port_t;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/mem_arb_perf_counter.sv
// mem_arb_perf_counter: 32-bit event counter (clk, rst, inc -> count) that saturates at all-ones
module mem_arb_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk) count <= rst ? '0 : count + {31'd0, inc & ~&count};
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises inst/data mem requests onto one word pmem port with alternating tie-break; perf counters under MEM_ARB_PERF_CNT_EN
module mem_port_arbiter
  import mem_arb_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_mem_read,
  input  logic [31:0] inst_mem_address,
  output logic [31:0] inst_mem_rdata,
  output logic        inst_mem_resp,
  input  logic        data_mem_read,
  input  logic        data_mem_write,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  input  logic [3:0]  data_mem_byte_enable,
  output logic [31:0] data_mem_rdata,
  output logic        data_mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic [31:0] perf_inst_grants,
  output logic [31:0] perf_data_grants,
  output logic [31:0] perf_conflict_cycles
);
  arb_state_t state;
  arb_port_t  grant, last_grant;
  logic       data_req, pick_data, start, store;
  assign data_req  = data_mem_read | data_mem_write;
  assign pick_data = data_req & (~inst_mem_read | (last_grant == PORT_INST));
  assign start     = (state == IDLE) & (inst_mem_read | data_req);
  assign store     = pick_data & data_mem_write;
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      grant            <= PORT_INST;
      last_grant       <= PORT_INST;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      pmem_byte_enable <= '0;
      inst_mem_rdata   <= '0;
      data_mem_rdata   <= '0;
      inst_mem_resp    <= 1'b0;
      data_mem_resp    <= 1'b0;
    end else begin
      inst_mem_resp <= 1'b0;
      data_mem_resp <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state            <= BUSY;
          grant            <= pick_data ? PORT_DATA : PORT_INST;
          pmem_address     <= (pick_data ? data_mem_address : inst_mem_address) & WORD_MASK;
          pmem_wdata       <= data_mem_wdata;
          pmem_byte_enable <= store ? data_mem_byte_enable : 4'hF;
          pmem_read        <= ~store;
          pmem_write       <= store;
        end
        BUSY: if (pmem_resp) begin
          state      <= RESP;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
          if (grant == PORT_INST) begin
            inst_mem_rdata <= pmem_rdata;
            inst_mem_resp  <= 1'b1;
          end else begin
            data_mem_resp <= 1'b1;
            if (pmem_read) data_mem_rdata <= pmem_rdata;
          end
        end
        RESP: begin
          state      <= IDLE;
          last_grant <= grant;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEM_ARB_PERF_CNT_EN
  mem_arb_perf_counter u_inst_cnt (.clk(clk), .rst(rst), .inc(start & ~pick_data), .count(perf_inst_grants));
  mem_arb_perf_counter u_data_cnt (.clk(clk), .rst(rst), .inc(start & pick_data), .count(perf_data_grants));
  mem_arb_perf_counter u_conf_cnt (.clk(clk), .rst(rst), .inc((state == IDLE) & inst_mem_read & data_req), .count(perf_conflict_cycles));
`else
  assign perf_inst_grants     = '0;
  assign perf_data_grants     = '0;
  assign perf_conflict_cycles = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_mem_read = 1'b0, inst_mem_resp;
  logic [31:0] inst_mem_address = '0, inst_mem_rdata;
  logic        data_mem_read = 1'b0, data_mem_write = 1'b0, data_mem_resp;
  logic [31:0] data_mem_address = '0, data_mem_wdata = '0, data_mem_rdata;
  logic [3:0]  data_mem_byte_enable = '0;
  logic        pmem_read, pmem_write, pmem_resp = 1'b0;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata = '0;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] perf_inst_grants, perf_data_grants, perf_conflict_cycles;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [31:0] mem [0:63];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_mem_read(inst_mem_read), .inst_mem_address(inst_mem_address),
    .inst_mem_rdata(inst_mem_rdata), .inst_mem_resp(inst_mem_resp),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .data_mem_byte_enable(data_mem_byte_enable), .data_mem_rdata(data_mem_rdata),
    .data_mem_resp(data_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_inst_grants(perf_inst_grants), .perf_data_grants(perf_data_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    inst_mem_read = 1'b0;
    data_mem_read = 1'b0;
    data_mem_write = 1'b0;
    pmem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Physical memory: waits (bounded) for a strobe, answers lat cycles later for one cycle,
  // returns one cycle after the answer, i.e. in the cycle the port response is due.
  task automatic serve(input int lat, output logic got, output logic [31:0] a, output logic [31:0] wd,
                       output logic [3:0] be, output logic wr, output logic [31:0] rd);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) if (pmem_read | pmem_write) got = 1'b1; else tick();
    a = pmem_address;
    wd = pmem_wdata;
    be = pmem_byte_enable;
    wr = pmem_write;
    rd = '0;
    if (got) begin
      repeat (lat) tick();
      rd = wr ? $urandom : mem[a[7:2]];
      if (wr) for (int b = 0; b < 4; b++) if (be[b]) mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
      pmem_rdata = rd;
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      pmem_rdata = $urandom;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    inst_mem_read = 1'b1;
    inst_mem_address = 32'h44;
    rst = 1'b1;
    tick();
    n_checks++; if ({pmem_read, pmem_write, inst_mem_resp, data_mem_resp} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {pmem_read, pmem_write, inst_mem_resp, data_mem_resp}); end
    n_checks++; if ({pmem_address, pmem_wdata, pmem_byte_enable} !== '0) begin n_fail++; $display("FAIL reset_pmem: got %h %h %h want zeros", pmem_address, pmem_wdata, pmem_byte_enable); end
    n_checks++; if ({inst_mem_rdata, data_mem_rdata} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", inst_mem_rdata, data_mem_rdata); end
    n_checks++; if ({perf_inst_grants, perf_data_grants, perf_conflict_cycles} !== 96'd0) begin n_fail++; $display("FAIL reset_perf: got %0d %0d %0d want 0", perf_inst_grants, perf_data_grants, perf_conflict_cycles); end
    apply_reset();
  endtask

  task automatic test_inst_read();
    logic got, wr;
    logic [31:0] a, wd, rd;
    logic [3:0] be;
    int c0;
    apply_reset();
    mem[1] = 32'hDEAD_BEEF;
    c0 = cyc;
    inst_mem_read = 1'b1;
    inst_mem_address = 32'h0000_0104;
    tick();
    n_checks++; if ({pmem_read, pmem_write} !== 2'b10) begin n_fail++; $display("FAIL inst_strobe: got %b want 10", {pmem_read, pmem_write}); end
    n_checks++; if (pmem_address !== 32'h0000_0104) begin n_fail++; $display("FAIL inst_addr: got %h want 00000104", pmem_address); end
    n_checks++; if (pmem_byte_enable !== 4'hF) begin n_fail++; $display("FAIL inst_be: got %h want f", pmem_byte_enable); end
    serve(3, got, a, wd, be, wr, rd);
    n_checks++; if (!got) begin n_fail++; $display("FAIL inst_serve: got no strobe want strobe"); end
    n_checks++; if (cyc - c0 != 5 || inst_mem_resp !== 1'b1) begin n_fail++; $display("FAIL inst_resp_cycle: got resp=%b at cycle %0d want 1 at 5", inst_mem_resp, cyc - c0); end
    n_checks++; if (inst_mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL inst_rdata: got %h want deadbeef", inst_mem_rdata); end
    n_checks++; if (pmem_read !== 1'b0 || data_mem_resp !== 1'b0) begin n_fail++; $display("FAIL inst_after: got pmem_read=%b data_resp=%b want 0 0", pmem_read, data_mem_resp); end
    inst_mem_read = 1'b0;
    tick();
    n_checks++; if (inst_mem_resp !== 1'b0 || inst_mem_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL inst_pulse: got resp=%b rdata=%h want 0 deadbeef", inst_mem_resp, inst_mem_rdata); end
    tick();
    n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL inst_no_refetch: got %b want 0", pmem_read); end
  endtask

  task automatic test_tie();
    logic got, wr;
    logic [31:0] a, wd, rd;
    logic [3:0] be;
    apply_reset();
    inst_mem_read = 1'b1;
    inst_mem_address = 32'h10;
    data_mem_read = 1'b1;
    data_mem_address = 32'h24;
    serve(2, got, a, wd, be, wr, rd);
    n_checks++; if (!got || a !== 32'h24 || data_mem_resp !== 1'b1 || inst_mem_resp !== 1'b0) begin n_fail++; $display("FAIL tie_first: got addr=%h dresp=%b iresp=%b want 24 1 0", a, data_mem_resp, inst_mem_resp); end
    data_mem_address = 32'h38;
    serve(1, got, a, wd, be, wr, rd);
    n_checks++; if (!got || a !== 32'h10 || inst_mem_resp !== 1'b1 || data_mem_resp !== 1'b0) begin n_fail++; $display("FAIL tie_second: got addr=%h iresp=%b dresp=%b want 10 1 0", a, inst_mem_resp, data_mem_resp); end
    inst_mem_address = 32'h44;
    serve(1, got, a, wd, be, wr, rd);
    n_checks++; if (!got || a !== 32'h38 || data_mem_resp !== 1'b1) begin n_fail++; $display("FAIL tie_third: got addr=%h dresp=%b want 38 1", a, data_mem_resp); end
    inst_mem_read = 1'b0;
    data_mem_read = 1'b0;
    tick();
`ifdef MEM_ARB_PERF_CNT_EN
    n_checks++; if ({perf_conflict_cycles, perf_inst_grants, perf_data_grants} !== {32'd3, 32'd1, 32'd2}) begin n_fail++; $display("FAIL tie_perf: got %0d %0d %0d want 3 1 2", perf_conflict_cycles, perf_inst_grants, perf_data_grants); end
`else
    n_checks++; if ({perf_conflict_cycles, perf_inst_grants, perf_data_grants} !== 96'd0) begin n_fail++; $display("FAIL tie_perf: got %0d %0d %0d want 0 0 0", perf_conflict_cycles, perf_inst_grants, perf_data_grants); end
`endif
  endtask

  task automatic test_store();
    logic got, wr;
    logic [31:0] a, wd, rd, prev;
    logic [3:0] be;
    apply_reset();
    mem[32] = 32'h5A5A_0F0F;
    data_mem_read = 1'b1;
    data_mem_address = 32'h80;
    serve(1, got, a, wd, be, wr, rd);
    n_checks++; if (!got || data_mem_rdata !== 32'h5A5A_0F0F) begin n_fail++; $display("FAIL store_preload: got %h want 5a5a0f0f", data_mem_rdata); end
    prev = data_mem_rdata;
    data_mem_read = 1'b0;
    data_mem_write = 1'b1;
    data_mem_address = 32'h0000_2003;
    data_mem_wdata = 32'h1122_3344;
    data_mem_byte_enable = 4'b1000;
    serve(2, got, a, wd, be, wr, rd);
    n_checks++; if (!got || a !== 32'h0000_2000 || wd !== 32'h1122_3344 || be !== 4'b1000 || wr !== 1'b1) begin n_fail++; $display("FAIL store_pmem: got a=%h wd=%h be=%b wr=%b want 2000 11223344 1000 1", a, wd, be, wr); end
    n_checks++; if (data_mem_resp !== 1'b1 || data_mem_rdata !== prev) begin n_fail++; $display("FAIL store_rdata: got resp=%b rdata=%h want 1 %h", data_mem_resp, data_mem_rdata, prev); end
    data_mem_write = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    logic got, wr;
    logic [31:0] a, wd, rd;
    logic [3:0] be;
    apply_reset();
    inst_mem_read = 1'b1;
    inst_mem_address = 32'h300;
    tick();
    for (int i = 0; i < 3; i++) begin
      inst_mem_address = $urandom;
      data_mem_wdata = $urandom;
      tick();
      n_checks++; if (pmem_address !== 32'h300 || pmem_read !== 1'b1) begin n_fail++; $display("FAIL hold_addr: got %h read=%b want 00000300 1", pmem_address, pmem_read); end
    end
    serve(1, got, a, wd, be, wr, rd);
    n_checks++; if (!got || inst_mem_resp !== 1'b1 || inst_mem_rdata !== rd) begin n_fail++; $display("FAIL hold_resp: got resp=%b rdata=%h want 1 %h", inst_mem_resp, inst_mem_rdata, rd); end
    inst_mem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    apply_reset();
    inst_mem_read = 1'b1;
    inst_mem_address = 32'h40;
    tick();
    tick();
    rst = 1'b1;
    inst_mem_read = 1'b0;
    tick();
    rst = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = 32'hCAFE_F00D;
    n_checks++; if ({pmem_read, pmem_write, pmem_address, pmem_byte_enable, inst_mem_resp} !== '0) begin n_fail++; $display("FAIL rstbusy_out: got rd=%b a=%h be=%h resp=%b want zeros", pmem_read, pmem_address, pmem_byte_enable, inst_mem_resp); end
    tick();
    pmem_resp = 1'b0;
    n_checks++; if ({inst_mem_resp, data_mem_resp, pmem_read} !== 3'b0 || inst_mem_rdata !== 32'd0) begin n_fail++; $display("FAIL rstbusy_late: got resp=%b%b read=%b rdata=%h want 000 0", inst_mem_resp, data_mem_resp, pmem_read, inst_mem_rdata); end
    tick();
    n_checks++; if ({inst_mem_resp, data_mem_resp, perf_inst_grants} !== '0) begin n_fail++; $display("FAIL rstbusy_quiet: got resp=%b%b perf=%0d want 00 0", inst_mem_resp, data_mem_resp, perf_inst_grants); end
  endtask

  task automatic test_held_read();
    logic got, wr;
    logic [31:0] a, wd, rd;
    logic [3:0] be;
    apply_reset();
    inst_mem_read = 1'b1;
    inst_mem_address = 32'h50;
    serve(2, got, a, wd, be, wr, rd);
    n_checks++; if (!got || inst_mem_resp !== 1'b1) begin n_fail++; $display("FAIL held_first: got resp=%b want 1", inst_mem_resp); end
    tick();
    n_checks++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL held_gap: got read=%b want 0", pmem_read); end
    tick();
    n_checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h50) begin n_fail++; $display("FAIL held_refetch: got read=%b a=%h want 1 50", pmem_read, pmem_address); end
    inst_mem_read = 1'b0;
    serve(1, got, a, wd, be, wr, rd);
    n_checks++; if (!got || inst_mem_resp !== 1'b1) begin n_fail++; $display("FAIL held_second: got resp=%b want 1", inst_mem_resp); end
    tick();
  endtask

  task automatic test_random();
    logic got, wr, pi, pd, dwr, win, last_data;
    logic [31:0] a, wd, rd, ia, da, dwd, exp_i, exp_d, ex_a;
    logic [3:0] be, dbe, ex_be;
    int gi, gd, cc;
    apply_reset();
    pi = 0; pd = 0; last_data = 0; exp_i = 0; exp_d = 0; gi = 0; gd = 0; cc = 0;
    ia = 0; da = 0; dwr = 0; dwd = 0; dbe = 0;
    for (int r = 0; r < 40; r++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ia = $urandom; end
      if (!pd && $urandom_range(0, 1) == 1) begin pd = 1; da = $urandom; dwr = 1'($urandom_range(0, 1)); dwd = $urandom; dbe = 4'($urandom_range(1, 15)); end
      if (!pi && !pd) begin pi = 1; ia = $urandom; end
      inst_mem_read = pi; inst_mem_address = ia;
      data_mem_read = pd & !dwr; data_mem_write = pd & dwr;
      data_mem_address = da; data_mem_wdata = dwd; data_mem_byte_enable = dbe;
      win = pd && (!pi || !last_data);
      if (pi && pd) cc++;
      if (win) gd++; else gi++;
      ex_a = (win ? da : ia) & 32'hFFFF_FFFC;
      ex_be = (win && dwr) ? dbe : 4'hF;
      serve($urandom_range(1, 4), got, a, wd, be, wr, rd);
      n_checks++; if (!got || a !== ex_a || wr !== (win && dwr) || be !== ex_be) begin n_fail++; $display("FAIL rand_req r%0d: got a=%h wr=%b be=%h want %h %b %h", r, a, wr, be, ex_a, win && dwr, ex_be); end
      if (win && dwr) begin
        n_checks++; if (wd !== dwd) begin n_fail++; $display("FAIL rand_wdata r%0d: got %h want %h", r, wd, dwd); end
      end
      if (!win) exp_i = rd; else if (!dwr) exp_d = rd;
      n_checks++; if ({inst_mem_resp, data_mem_resp} !== {!win, win}) begin n_fail++; $display("FAIL rand_resp r%0d: got %b%b want %b%b", r, inst_mem_resp, data_mem_resp, !win, win); end
      n_checks++; if (inst_mem_rdata !== exp_i || data_mem_rdata !== exp_d) begin n_fail++; $display("FAIL rand_rdata r%0d: got %h %h want %h %h", r, inst_mem_rdata, data_mem_rdata, exp_i, exp_d); end
      last_data = win;
      if (win) pd = 0; else pi = 0;
      inst_mem_read = pi;
      data_mem_read = pd & !dwr; data_mem_write = pd & dwr;
    end
    inst_mem_read = 0; data_mem_read = 0; data_mem_write = 0;
    if (pi || pd) begin
      pi = 0; pd = 0;
    end
    tick();
    tick();
`ifdef MEM_ARB_PERF_CNT_EN
    n_checks++; if (perf_inst_grants !== 32'(gi) || perf_data_grants !== 32'(gd) || perf_conflict_cycles !== 32'(cc)) begin n_fail++; $display("FAIL rand_perf: got %0d %0d %0d want %0d %0d %0d", perf_inst_grants, perf_data_grants, perf_conflict_cycles, gi, gd, cc); end
`else
    n_checks++; if ({perf_inst_grants, perf_data_grants, perf_conflict_cycles} !== 96'd0) begin n_fail++; $display("FAIL rand_perf: got %0d %0d %0d want 0 0 0 (%0d %0d %0d events)", perf_inst_grants, perf_data_grants, perf_conflict_cycles, gi, gd, cc); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    test_reset();
    test_inst_read();
    test_tie();
    test_store();
    test_addr_change();
    test_reset_busy();
    test_held_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
